// File: rtl/barrel_rr_sched.sv
// Round-robin front end for one shared combinational rotate-right datapath.
// Two requesters compete in IDLE; the winner's operand is issued, captured and held until taken.
module barrel_rr_sched #(
   parameter int WIDTH = 8,
   parameter int SELW  = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req0_valid,
   input  logic [WIDTH-1:0] req0_data,
   input  logic [SELW-1:0]  req0_sel,
   output logic             req0_ready,
   input  logic             req1_valid,
   input  logic [WIDTH-1:0] req1_data,
   input  logic [SELW-1:0]  req1_sel,
   output logic             req1_ready,
   output logic [WIDTH-1:0] brl_data,
   output logic [SELW-1:0]  brl_sel,
   input  logic [WIDTH-1:0] brl_result,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_id,
   output logic             busy,
   output logic [7:0]       done_cnt,
   output logic [1:0]       state_dbg
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      HOLD  = 2'd2
   } state_t;

   state_t state_q;
   state_t state_d;
   logic   ptr_q;      // 0: requester 0 wins a tie, 1: requester 1 wins
   logic   grant_any;
   logic   grant_id;
   logic   accept;
   logic   out_fire;

   // Handshake rule on every port: a transfer happens on the rising edge where
   // valid and ready are both high; ready never depends on anything but state and valids.
   always_comb begin
      grant_any = req0_valid | req1_valid;
      grant_id  = 1'b0;
      if (req0_valid && req1_valid) begin
         grant_id = ptr_q;
      end else if (req1_valid) begin
         grant_id = 1'b1;
      end
   end

   assign accept     = (state_q == IDLE) && grant_any;
   assign req0_ready = accept && !grant_id;
   assign req1_ready = accept && grant_id;
   assign out_fire   = (state_q == HOLD) && out_ready;
   assign busy       = (state_q != IDLE);
   assign state_dbg  = state_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (grant_any) state_d = ISSUE;
         ISSUE:   state_d = HOLD;
         HOLD:    if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // brl_data/brl_sel change only on a grant so the rotator output is settled in ISSUE.
   always_ff @(posedge clk) begin
      if (reset) begin
         brl_data  <= '0;
         brl_sel   <= '0;
         out_id    <= 1'b0;
         out_data  <= '0;
         out_valid <= 1'b0;
         done_cnt  <= 8'd0;
         ptr_q     <= 1'b0;
      end else begin
         if (accept) begin
            brl_data <= grant_id ? req1_data : req0_data;
            brl_sel  <= grant_id ? req1_sel  : req0_sel;
            out_id   <= grant_id;
            ptr_q    <= ~grant_id;
         end
         if (state_q == ISSUE) begin
            out_data  <= brl_result;
            out_valid <= 1'b1;
         end
         if (out_fire) begin
            out_valid <= 1'b0;
            done_cnt  <= done_cnt + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_barrel_rr_sched.sv
// Directed bench for barrel_rr_sched: the bench itself plays the shared rotator
// and compares every observation against hand-computed values.
module tb_barrel_rr_sched;

   logic       clk = 1'b0;
   logic       reset;
   logic       req0_valid, req1_valid;
   logic [7:0] req0_data, req1_data;
   logic [2:0] req0_sel, req1_sel;
   logic       req0_ready, req1_ready;
   logic [7:0] brl_data, brl_result;
   logic [2:0] brl_sel;
   logic       out_valid, out_ready, out_id, busy;
   logic [7:0] out_data, done_cnt;
   logic [1:0] state_dbg;
   logic [15:0] rot_dd;

   int total = 0;
   int bad   = 0;
   int exp_done = 0;
   logic [8:0] exp_q[$];

   always #5 clk = ~clk;

   // External rotator: brl_data rotated right by brl_sel.
   assign rot_dd     = {brl_data, brl_data} >> brl_sel;
   assign brl_result = rot_dd[7:0];

   barrel_rr_sched #(.WIDTH(8), .SELW(3)) dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_data(req0_data), .req0_sel(req0_sel), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_data(req1_data), .req1_sel(req1_sel), .req1_ready(req1_ready),
      .brl_data(brl_data), .brl_sel(brl_sel), .brl_result(brl_result),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_id(out_id),
      .busy(busy), .done_cnt(done_cnt), .state_dbg(state_dbg)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_out_valid"}, out_valid, 0);
      check({tag, "_out_data"},  out_data, 0);
      check({tag, "_out_id"},    out_id, 0);
      check({tag, "_brl_data"},  brl_data, 0);
      check({tag, "_brl_sel"},   brl_sel, 0);
      check({tag, "_done_cnt"},  done_cnt, 0);
      check({tag, "_busy"},      busy, 0);
      check({tag, "_state"},     state_dbg, 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      exp_done = 0;
   endtask

   // One operation from requester id with out_ready held high.
   task automatic do_op(input int id, input logic [7:0] data, input logic [2:0] sel,
                        input logic [7:0] exp_res);
      int n = 0;
      @(negedge clk);
      if (id == 0) begin req0_valid = 1'b1; req0_data = data; req0_sel = sel; end
      else         begin req1_valid = 1'b1; req1_data = data; req1_sel = sel; end
      #1;
      while (!((id == 0) ? req0_ready : req1_ready) && n < 20) begin
         @(negedge clk); #1; n++;
      end
      check("op_ready", (id == 0) ? req0_ready : req1_ready, 1);
      check("op_other_ready", (id == 0) ? req1_ready : req0_ready, 0);
      @(negedge clk);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      #1;
      check("op_issue_busy", busy, 1);
      check("op_issue_nready", req0_ready | req1_ready, 0);
      check("op_issue_valid", out_valid, 0);
      check("op_brl_data", brl_data, data);
      check("op_brl_sel", brl_sel, sel);
      @(negedge clk);
      check("op_out_valid", out_valid, 1);
      check("op_out_data", out_data, exp_res);
      check("op_out_id", out_id, id);
      exp_done = (exp_done + 1) % 256;
      @(negedge clk);
      check("op_out_drop", out_valid, 0);
      check("op_done_cnt", done_cnt, exp_done);
      check("op_idle", busy, 0);
   endtask

   initial begin
      reset = 1'b1;
      req0_valid = 1'b0; req0_data = 8'h00; req0_sel = 3'd0;
      req1_valid = 1'b0; req1_data = 8'h00; req1_sel = 3'd0;
      out_ready = 1'b1;
      repeat (2) @(negedge clk);
      check_reset_values("rst");
      reset = 1'b0;
      @(negedge clk);
      check("idle_no_ready", req0_ready | req1_ready, 0);

      // Basic rotations, including sel=0 and sel=WIDTH-1.
      do_op(0, 8'h81, 3'd1, 8'hC0);
      do_op(1, 8'h01, 3'd7, 8'h02);
      do_op(1, 8'hA5, 3'd4, 8'h5A);
      do_op(0, 8'h3C, 3'd0, 8'h3C);

      // Both requesters valid continuously: grants must alternate starting at 0.
      begin
         logic       dual_seen;
         int         grants, outs, cyc;
         logic [8:0] e;
         logic       exp_grant [4];
         exp_grant[0] = 1'b0; exp_grant[1] = 1'b1; exp_grant[2] = 1'b0; exp_grant[3] = 1'b1;
         do_reset();
         dual_seen = 1'b0; grants = 0; outs = 0; cyc = 0;
         req0_valid = 1'b1; req0_data = 8'h10; req0_sel = 3'd1;
         req1_valid = 1'b1; req1_data = 8'h10; req1_sel = 3'd2;
         out_ready = 1'b1;
         while (outs < 4 && cyc < 40) begin
            #1;
            if (req0_ready && req1_ready) dual_seen = 1'b1;
            if ((req0_ready || req1_ready) && grants < 4) begin
               check("alt_grant", req1_ready, exp_grant[grants]);
               exp_q.push_back(req1_ready ? {1'b1, 8'h04} : {1'b0, 8'h08});
               grants++;
            end
            if (out_valid && out_ready) begin
               e = (exp_q.size() > 0) ? exp_q.pop_front() : 9'h1FF;
               check("alt_result", {out_id, out_data}, e);
               outs++;
            end
            @(negedge clk);
            cyc++;
         end
         check("alt_outs_seen", outs, 4);
         check("alt_one_ready", dual_seen, 0);
         req0_valid = 1'b0;
         req1_valid = 1'b0;
         exp_q.delete();
      end

      // Backpressure: result held through 5 cycles of out_ready low.
      do_reset();
      @(negedge clk);
      out_ready = 1'b0;
      req0_valid = 1'b1; req0_data = 8'h81; req0_sel = 3'd3;
      #1;
      check("bp_ready0", req0_ready, 1);
      @(negedge clk);
      req0_valid = 1'b0;
      req1_valid = 1'b1; req1_data = 8'hFF; req1_sel = 3'd1;
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         #1;
         check("bp_valid", out_valid, 1);
         check("bp_data", out_data, 8'h30);
         check("bp_id", out_id, 0);
         check("bp_no_ready", req0_ready | req1_ready, 0);
         check("bp_done", done_cnt, 0);
         @(negedge clk);
      end
      out_ready = 1'b1;
      @(negedge clk);
      req1_valid = 1'b0;   // drops without a handshake
      #1;
      check("bp_released", out_valid, 0);
      check("bp_done_inc", done_cnt, 1);
      check("bp_idle", busy, 0);
      @(negedge clk);
      check("bp_drop_idle", busy, 0);

      // Reset while in ISSUE: pointer was moved to 1 by the req0 grant.
      @(negedge clk);
      req0_valid = 1'b1; req0_data = 8'h55; req0_sel = 3'd2;
      @(negedge clk);
      req0_valid = 1'b0;
      check("ri_in_issue", state_dbg, 1);
      reset = 1'b1;
      @(negedge clk);
      check_reset_values("ri");
      reset = 1'b0;
      req0_valid = 1'b1; req0_data = 8'h02; req0_sel = 3'd1;
      req1_valid = 1'b1; req1_data = 8'h04; req1_sel = 3'd1;
      #1;
      check("ri_ptr0", req0_ready, 1);
      check("ri_ptr1", req1_ready, 0);

      // Reset while in HOLD (req0 granted above, so pointer favours 1 again).
      out_ready = 1'b0;
      @(negedge clk);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      @(negedge clk);
      check("rh_in_hold", state_dbg, 2);
      check("rh_data", out_data, 8'h01);
      reset = 1'b1;
      @(negedge clk);
      check_reset_values("rh");
      reset = 1'b0;
      out_ready = 1'b1;
      req0_valid = 1'b1; req1_valid = 1'b1;
      #1;
      check("rh_ptr0", req0_ready, 1);
      check("rh_ptr1", req1_ready, 0);
      req0_valid = 1'b0; req1_valid = 1'b0;

      // 256 completions wrap done_cnt back to zero.
      begin
         int outs, cyc;
         do_reset();
         outs = 0; cyc = 0;
         out_ready = 1'b1;
         req0_valid = 1'b1; req0_data = 8'h01; req0_sel = 3'd1;
         while (outs < 256 && cyc < 1000) begin
            #1;
            if (out_valid && out_ready) begin
               if (outs == 255) check("wrap_255", done_cnt, 255);
               outs++;
            end
            @(negedge clk);
            cyc++;
         end
         req0_valid = 1'b0;
         check("wrap_outs", outs, 256);
         #1;
         check("wrap_zero", done_cnt, 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
